// File: rtl/uart_tx_port_if.sv
// CPU console bus seen by the UART transmitter: address, write strobe and data,
// plus the combinational read-back data returned to the CPU.
interface uart_tx_port_if;
   logic [15:0] address;
   logic        write_en;
   logic [7:0]  data_in;
   logic [7:0]  data_out;

   modport master (output address, output write_en, output data_in, input data_out);
   modport slave  (input address, input write_en, input data_in, output data_out);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped console UART transmitter: FIFO-buffered CPU byte writes shifted out
// as LSB-first serial frames. Define UART_PARITY_EN to add an even-parity bit.
module uart_tx_port #(
   parameter logic [15:0] BASE_ADDR    = 16'hF010,
   parameter int          FIFO_DEPTH   = 4,
   parameter int          CLKS_PER_BIT = 16
) (
   input  logic           clock,
   input  logic           reset,
   uart_tx_port_if.slave  bus,
   output logic           tx,
   output logic           irq_empty
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [15:0]       STAT_ADDR = BASE_ADDR + 16'd1;
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_PARITY_EN
   localparam logic [2:0] PARITY = 3'd4;
   localparam logic       PAR_FLAG = 1'b1;
`else
   localparam logic       PAR_FLAG = 1'b0;
`endif

   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              overflow_q;

   logic [2:0]        state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_d;
`ifdef UART_PARITY_EN
   logic              parity_q;
`endif

   logic full, empty, busy, baud_end;
   logic push_req, push_ok, pop, clear_ovf;

   assign full     = (count_q == CNT_FULL);
   assign empty    = (count_q == '0);
   assign busy     = (state_q != IDLE);
   assign baud_end = (baud_q == BAUD_LAST);

   assign push_req  = bus.write_en && (bus.address == BASE_ADDR);
   assign push_ok   = push_req && (!full || pop);
   assign clear_ovf = bus.write_en && (bus.address == STAT_ADDR) && bus.data_in[3];

   assign bus.data_out = (!bus.write_en && (bus.address == STAT_ADDR))
                       ? {3'b000, PAR_FLAG, overflow_q, empty, full, busy} : 8'h00;
   assign irq_empty = empty && !busy;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      baud_d  = '0;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      if (state_q != IDLE)
         baud_d = baud_end ? '0 : baud_q + BAUD_ONE;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_mem[rd_ptr_q];
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               state_d = DATA;
               bit_d   = 3'd0;
            end
         end
         DATA: begin
            if (baud_end) begin
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
               end
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (baud_end)
               state_d = STOP;
         end
`endif
         STOP: begin
            if (baud_end) begin
               // Chain straight into the next start bit when more data is queued.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_mem[rd_ptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // tx is registered from the next state so the line changes on the same edge as the FSM.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_PARITY_EN
         PARITY:  tx_d = parity_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= 3'd0;
         shift_q    <= 8'h00;
         tx         <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx      <= tx_d;
         if (push_ok)
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
         if (push_req && !push_ok)
            overflow_q <= 1'b1;
         else if (clear_ovf)
            overflow_q <= 1'b0;
      end
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         parity_q <= 1'b0;
      else if (pop)
         parity_q <= ^fifo_mem[rd_ptr_q];
   end
`endif

   // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clock) begin
      if (push_ok)
         fifo_mem[wr_ptr_q] <= bus.data_in;
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: reset, single and back-to-back frames, overflow,
// mid-frame reset and address decode, with hand-computed expected values.
module tb_uart_tx_port;

   localparam int CPB = 4;
`ifdef UART_PARITY_EN
   localparam int          NBITS   = 11;
   localparam logic [7:0]  ST_FLAG = 8'h10;
`else
   localparam int          NBITS   = 10;
   localparam logic [7:0]  ST_FLAG = 8'h00;
`endif
   localparam logic [7:0] ST_IDLE = 8'h04 | ST_FLAG;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic tx, irq_empty;
   int   total = 0;
   int   bad   = 0;

   uart_tx_port_if bus ();

   uart_tx_port #(
      .BASE_ADDR   (16'hF010),
      .FIFO_DEPTH  (4),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .tx       (tx),
      .irq_empty(irq_empty)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one write, returns at the falling edge after the sampling edge.
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      bus.address  = a;
      bus.write_en = 1'b1;
      bus.data_in  = d;
      @(negedge clock);
   endtask

   task automatic bus_read(input logic [15:0] a);
      bus.address  = a;
      bus.write_en = 1'b0;
      bus.data_in  = 8'h00;
      #1;
   endtask

   function automatic logic expect_bit(input logic [7:0] d, input int i);
      if (i == 0)
         return 1'b0;
      else if (i <= 8)
         return d[i-1];
      else if (i == 9 && NBITS == 11)
         return ^d;
      else
         return 1'b1;
   endfunction

   // Starts at frame cycle first_k; bus must be addressing the status register.
   task automatic check_frame(input logic [7:0] d, input int first_k);
      for (int k = first_k; k < NBITS * CPB; k++) begin
         check($sformatf("frame %02h cyc %0d tx", d, k), tx, expect_bit(d, k / CPB));
         check($sformatf("frame %02h cyc %0d busy", d, k), bus.data_out[0], 1'b1);
         @(negedge clock);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " status"}, bus.data_out, ST_IDLE);
      check({tag, " tx"}, tx, 1'b1);
      check({tag, " irq_empty"}, irq_empty, 1'b1);
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      int lows;
      lows = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (tx !== 1'b1) lows++;
      end
      check({tag, " tx low cycles"}, lows, 0);
   endtask

   initial begin
      bus.address  = 16'h0000;
      bus.write_en = 1'b0;
      bus.data_in  = 8'h00;

      // Reset and idle status
      repeat (3) @(negedge clock);
      check("in reset tx", tx, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      bus_read(16'hF011);
      check_idle("reset idle");

      // Single byte: start bit appears one edge after the write is sampled
      bus_write(16'hF010, 8'h41);
      check("single latency tx", tx, 1'b1);
      check("single irq_empty", irq_empty, 1'b0);
      bus_read(16'hF011);
      @(negedge clock);
      check_frame(8'h41, 0);
      check_idle("single done");

      // Back-to-back frames with no idle gap
      bus_write(16'hF010, 8'h41);
      bus_write(16'hF010, 8'h42);
      bus_write(16'hF010, 8'h43);
      bus_read(16'hF011);
      check_frame(8'h41, 1);
      check_frame(8'h42, 0);
      check_frame(8'h43, 0);
      check_idle("b2b done");

      // Overflow: A0 popped, A1..A4 buffered, A5 dropped
      for (int i = 0; i < 6; i++)
         bus_write(16'hF010, 8'hA0 + 8'(i));
      bus_read(16'hF011);
      check("ovf status", bus.data_out, 8'h0B | ST_FLAG);
      bus_write(16'hF011, 8'h08);
      bus_read(16'hF011);
      check("ovf cleared status", bus.data_out, 8'h03 | ST_FLAG);
      check_frame(8'hA0, 5);
      for (int i = 1; i < 5; i++)
         check_frame(8'hA0 + 8'(i), 0);
      check_idle("ovf drained");

      // Reset during DATA with a second byte still queued
      bus_write(16'hF010, 8'hC3);
      bus_write(16'hF010, 8'h3C);
      bus_read(16'hF011);
      repeat (12) @(negedge clock);
      check("pre-reset tx", tx, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("async reset tx", tx, 1'b1);
      check("async reset irq_empty", irq_empty, 1'b1);
      @(negedge clock);
      reset = 1'b1;
      bus_read(16'hF011);
      check_idle("after mid reset");
      watch_quiet("after mid reset", 60);

      // Address decode
      bus_write(16'hF012, 8'h55);
      bus_write(16'hF00F, 8'h55);
      bus_read(16'hF011);
      check_idle("decode");
      watch_quiet("decode", 20);
      bus_read(16'hF010);
      check("read data reg", bus.data_out, 8'h00);
      bus.address  = 16'hF011;
      bus.write_en = 1'b1;
      bus.data_in  = 8'h00;
      #1;
      check("status read with write_en", bus.data_out, 8'h00);
      @(negedge clock);
      bus_read(16'hF011);
      check_idle("decode end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
Memory-mapped UART transmitter that sits directly downstream of the CPU bus and consumes the CPU's byte writes to the console address. Accepted bytes are buffered in a small FIFO and shifted out as 8N1 serial frames, LSB first. A combinational status register lets firmware poll busy/full/overflow. The bus interface matches the CPU's address, write_en and data_out timing, so the block can replace the testbench's `$write` console tap.

Parameters:
- BASE_ADDR, 16'hF010, address of the TX data register; status register is at BASE_ADDR+1.
- FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 16, clock cycles per serial bit; minimum 2.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- address  input  16  CPU bus address.
- write_en  input  1  CPU write strobe; sampled on the rising edge.
- data_in  input  8  CPU write data (the CPU's data_out).
- data_out  output  8  read data; combinational.
- tx  output  1  serial line; registered; idle high.
- irq_empty  output  1  high when the FIFO is empty and the FSM is IDLE (transmitter fully drained).

Behaviour:
- Reset (reset==0, asynchronous):
  - tx=1, FSM=IDLE, FIFO count=0, read/write pointers=0, overflow=0, baud counter=0, bit index=0.
  - Any frame in flight is abandoned immediately; FIFO contents are discarded.
- Push: on a rising edge with write_en==1 and address==BASE_ADDR.
  - Accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - Otherwise the byte is dropped and sticky overflow is set to 1.
- Status register, write: on a rising edge with write_en==1 and address==BASE_ADDR+1, if data_in[3]==1 then overflow is cleared. All other bits are ignored.
- data_out:
  - When write_en==0 and address==BASE_ADDR+1, data_out = {4'b0, overflow, empty, full, busy}.
  - In all other cases data_out=0, including reads of BASE_ADDR.
  - busy = (FSM != IDLE).
- FSM states: IDLE, START, DATA, STOP. Every non-IDLE state lasts CLKS_PER_BIT cycles, counted by the baud counter from 0 to CLKS_PER_BIT-1.
  - IDLE: tx=1. If the FIFO is non-empty at a rising edge, pop the head into the shift register and enter START.
  - START: tx=0.
  - DATA: tx = shift[0]. At the end of each bit, shift right. Leave DATA after 8 bits.
  - STOP: tx=1. At the end of STOP, if the FIFO is non-empty, pop and enter START directly (back-to-back frames, no idle gap); otherwise enter IDLE.
- Latency:
  - A write sampled at edge N into an empty FIFO with the FSM in IDLE produces tx=0 after edge N+1.
  - Frame length is 10*CLKS_PER_BIT cycles.
- Boundaries:
  - Push into an empty FIFO cannot be popped on the same edge.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- Writes to any other address are ignored entirely.

Optional Feature:
UART_PARITY_EN
- Defined: a PARITY state follows DATA and lasts CLKS_PER_BIT cycles. tx = even parity (XOR of the 8 data bits). Frame length becomes 11*CLKS_PER_BIT. Status bit 4 reads 1.
- Undefined: 8N1 frames as described above; status bit 4 reads 0.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=F010):
- Reset idle: pulse reset low; read F011 → data_out=8'h04, tx=1, irq_empty=1.
- Single byte: write 8'h41 to F010 at edge N.
  - tx=0 for cycles N+1..N+4, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop=1.
  - busy=1 for 40 cycles, then irq_empty=1.
- Back-to-back: write 8'h41,8'h42,8'h43 on consecutive edges → three frames with no idle gap between stop and start; total 120 cycles of busy.
- Overflow: write 6 bytes on consecutive edges.
  - The first byte is popped, 4 are buffered, and the 6th is dropped.
  - Read F011 → 8'h0B (overflow, full, busy).
  - Write 8'h08 to F011 → overflow reads 0.
- Reset mid-frame: assert reset during the DATA state of a frame → tx=1 within the same cycle; after release F011=8'h04 and no further frames are emitted.
- Decode: write 8'h55 to F012 and F00F → no frame, no status change. Read F010 → data_out=0. Read F011 while write_en=1 → data_out=0.
